booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand width in bits; legal range 4 to 32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port start, input, 1 bit, SHALL request a new multiply.
REQ-005 Port signed_mode, input, 1 bit, SHALL select the operand type: 1 = two's-complement, 0 = unsigned. It is sampled with start.
REQ-006 Ports a and b, inputs, WIDTH bits each, SHALL be the multiplicand and multiplier. They are sampled with start.
REQ-007 Port busy, output, 1 bit, SHALL be high while an operation is in progress.
REQ-008 Port done, output, 1 bit, SHALL be a one-cycle pulse that marks p valid.
REQ-009 Port p, output, 2*WIDTH bits, SHALL carry the product.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 The block SHALL accept start only when the state is IDLE or DONE.
REQ-012 On acceptance the block SHALL:
- capture a, b and signed_mode;
- load the accumulator with 0;
- set Q0 (prior bit) to 0;
- zero the iteration counter;
- enter RUN.
REQ-013 Operands SHALL be extended internally to WIDTH+1 bits:
- sign-extended when signed_mode = 1;
- zero-extended when signed_mode = 0.
REQ-014 In RUN, each cycle SHALL perform one radix-2 Booth step on {Q[0], Q0}:
- 10: accumulator minus multiplicand;
- 01: accumulator plus multiplicand;
- 00 or 11: no add.
- Then an arithmetic right shift of {accumulator, Q, Q0} by one bit.
REQ-015 RUN SHALL last exactly WIDTH+1 cycles. After the final step the FSM SHALL enter DONE.
REQ-016 If start is sampled at edge k, done SHALL be high for the single cycle following edge k+WIDTH+1.
REQ-017 p SHALL be the low 2*WIDTH bits of the final {accumulator, Q} result. This SHALL be the exact product for every operand pair in both modes.
REQ-018 p SHALL update only on entry to DONE. It SHALL hold its value until the next entry to DONE.
REQ-019 busy SHALL be high in RUN and low in IDLE and DONE.
REQ-020 DONE SHALL last one cycle. It SHALL go to RUN if start is high that cycle, otherwise to IDLE. This allows back-to-back operation with no idle cycle.
REQ-021 start while busy is high SHALL be ignored. Changes on a, b or signed_mode during RUN SHALL have no effect on the result.
REQ-022 Accumulator add and subtract SHALL be WIDTH+1 bits wide with carry-out discarded. No overflow flag is produced.

Reset
REQ-023 While rst_n is low, the block SHALL hold these values:
- state = IDLE;
- busy = 0;
- done = 0;
- p = 0;
- accumulator, Q, Q0 and counter = 0.
REQ-024 Assertion of rst_n mid-operation SHALL abort the operation immediately. No done pulse SHALL be produced for the aborted operation.
REQ-025 After rst_n deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-026 A shared package, booth_pkg, SHALL hold:
- the FSM state enumeration;
- the 2-bit Booth operation encoding (NOP, ADD, SUB);
- the default WIDTH constant.
REQ-027 One combinational sub-module, booth_step, parametrised by width, SHALL perform one add/subtract plus arithmetic shift. It SHALL be instantiated once.
REQ-028 The iteration counter SHALL be $clog2(WIDTH+2) bits wide.

Verification
REQ-029 WIDTH=16, signed, a=0x8000, b=0x8000 -> p=0x40000000; done exactly 17 cycles after start.
REQ-030 WIDTH=16, unsigned, a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. The same operands in signed mode -> p=0x00000001.
REQ-031 WIDTH=16, signed, a=0xFFFF (-1), b=0x0001 -> p=0xFFFFFFFF. A second start held high during DONE with a=3, b=5 -> p=0x0000000F, and busy does not drop between the two operations.
REQ-032 rst_n pulsed low 5 cycles into RUN -> busy=0, p=0, no done pulse. The next start with a=7, b=6 -> p=42.
REQ-033 start re-asserted with new operands during RUN -> ignored; the original product is delivered.
REQ-034 WIDTH=8, unsigned, a=0xFF, b=0xFF -> p=0xFE01. Signed, a=0x80, b=0x7F -> p=0xC080. Done 9 cycles after start.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// booth_pkg: shared types for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic q_lsb, input logic q_prev);
    case ({q_lsb, q_prev})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// booth_step: one Booth add/subtract followed by an arithmetic right shift of {acc, q, q0}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] q,
  input  logic           q0,
  input  logic [WIDTH:0] mcand,
  output logic [WIDTH:0] acc_next,
  output logic [WIDTH:0] q_next,
  output logic           q0_next
);

  booth_op_t      op;
  logic [WIDTH:0] sum;

  always_comb begin
    op  = booth_decode(q[0], q0);
    sum = acc;
    case (op)
      OP_ADD:  sum = acc + mcand;
      OP_SUB:  sum = acc - mcand;
      default: sum = acc;
    endcase
    // Carry-out is dropped; the shifted-in bit is the sum's own sign.
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH:1]};
    q0_next  = q[0];
  end

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// booth_mul_seq: sequential radix-2 Booth multiplier, signed or unsigned,
// one Booth step per cycle over WIDTH+1 extended operand bits.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t         state, state_next;
  logic           accept;
  logic [WIDTH:0] acc, q, mcand;
  logic           q0;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0] a_ext, b_ext;
  logic [WIDTH:0] acc_next, q_next;
  logic           q0_next;

  assign a_ext = {signed_mode & a[WIDTH-1], a};
  assign b_ext = {signed_mode & b[WIDTH-1], b};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q0       (q0),
    .mcand    (mcand),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q0_next  (q0_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      q     <= '0;
      q0    <= 1'b0;
      mcand <= '0;
      cnt   <= '0;
      p     <= '0;
    end else if (accept) begin
      acc   <= '0;
      q     <= b_ext;
      q0    <= 1'b0;
      mcand <= a_ext;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      q   <= q_next;
      q0  <= q0_next;
      cnt <= cnt + 1'b1;
      // Low 2*WIDTH bits of {acc, q} hold the exact product for W-bit operands.
      if (cnt == LAST) p <= {acc_next[WIDTH-2:0], q_next};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// tb_booth_mul_seq: scoreboard bench for 16-bit and 8-bit instances.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 0, sm16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  logic        start8 = 0, sm8 = 0, busy8, done8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  booth_mul_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  booth_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  int total = 0;
  int bad   = 0;
  int nn    = 0;

  typedef struct {
    logic [31:0] p;
    int          at;
  } exp_t;
  exp_t q16[$];
  exp_t q8[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] xa, xb;
    xa = sm ? {{16{a[15]}}, a} : {16'b0, a};
    xb = sm ? {{16{b[15]}}, b} : {16'b0, b};
    return xa * xb;
  endfunction

  function automatic logic [15:0] m8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa, xb;
    xa = sm ? {{8{a[7]}}, a} : {8'b0, a};
    xb = sm ? {{8{b[7]}}, b} : {8'b0, b};
    return xa * xb;
  endfunction

  // Negedge index counts let done latency be checked against the start edge.
  always @(negedge clk) begin
    exp_t e;
    nn++;
    if (done16) begin
      if (q16.size() == 0) check("spur16", 1, 0);
      else begin
        e = q16.pop_front();
        check("p16", p16, e.p);
        check("lat16", nn, e.at);
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("spur8", 1, 0);
      else begin
        e = q8.pop_front();
        check("p8", p8, e.p);
        check("lat8", nn, e.at);
      end
    end
  end

  // Called just after a rising edge; start is sampled on the next one.
  task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input bit push);
    start16 = 1; sm16 = sm; a16 = a; b16 = b;
    if (push) q16.push_back('{exp, nn + 16 + 3});
    @(posedge clk); #1;
    start16 = 0; sm16 = ~sm; a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    start8 = 1; sm8 = sm; a8 = a; b8 = b;
    q8.push_back('{{16'b0, exp}, nn + 8 + 3});
    @(posedge clk); #1;
    start8 = 0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain16();
    repeat (20) @(posedge clk);
    #1;
    check("drain16", q16.size(), 0);
    q16.delete();
  endtask

  task automatic drain8();
    repeat (12) @(posedge clk);
    #1;
    check("drain8", q8.size(), 0);
    q8.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        sm;
    logic [15:0] ra, rb;
    logic [7:0]  sa, sb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_p16", p16, 0);
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    check("rst_p8", p8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    rst_n = 1;
    @(posedge clk); #1;

    issue16(1, 16'h8000, 16'h8000, 32'h4000_0000, 1); drain16();
    issue16(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1); drain16();
    issue16(1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1); drain16();

    // Back-to-back: second start held high in the DONE cycle.
    issue16(1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 1);
    repeat (17) @(posedge clk);
    #1;
    issue16(1, 16'h0003, 16'h0005, 32'h0000_000F, 1);
    check("b2b_busy", busy16, 1);
    drain16();

    // Abort five cycles into RUN; restart on the edge right after release.
    issue16(1, 16'h1234, 16'h5678, 32'h0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    check("abort_busy", busy16, 0);
    check("abort_p", p16, 0);
    check("abort_done", done16, 0);
    @(posedge clk); #1;
    rst_n = 1;
    issue16(0, 16'h0007, 16'h0006, 32'd42, 1);
    drain16();

    // start during RUN with other operands must be ignored.
    issue16(1, 16'h0123, 16'hFF00, 32'hFFFE_DD00, 1);
    repeat (3) @(posedge clk);
    #1;
    start16 = 1; sm16 = 0; a16 = 16'h0007; b16 = 16'h0007;
    @(posedge clk); #1;
    start16 = 0;
    drain16();

    for (int i = 0; i < 12; i++) begin
      sm = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue16(sm, ra, rb, m16(sm, ra, rb), 1);
      drain16();
    end

    issue8(0, 8'hFF, 8'hFF, 16'hFE01); drain8();
    issue8(1, 8'h80, 8'h7F, 16'hC080); drain8();
    for (int i = 0; i < 12; i++) begin
      sm = 1'($urandom);
      sa = 8'($urandom);
      sb = 8'($urandom);
      issue8(sm, sa, sb, m8(sm, sa, sb));
      drain8();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
